iob_vga_ctrl: RTL and testbench



---
 rtl/iob_vga_ctrl.sv | 102 ++++++++++
 tb/tb_iob_vga_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_vga_ctrl.sv
// VGA raster controller: free-running pixel counters, blanked RGB444 output
// and sync pulses, all registered on the pixel tick so colour and sync stay aligned.
module iob_vga_ctrl #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  vga_pixel_x,
    output logic [9:0]  vga_pixel_y,
    input  logic [11:0] vga_rgb_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so a 1024-wide region still compares correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_IDLE = (SYNC_POL == 0);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic [11:0]      r_rgb;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;

    logic w_tick;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_hs_act;
    logic w_vs_act;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_active = ({1'b0, r_h_cnt} < H_ACT_END) && ({1'b0, r_v_cnt} < V_ACT_END);
    assign w_hs_act = ({1'b0, r_h_cnt} >= HS_BEG) && ({1'b0, r_h_cnt} < HS_END);
    assign w_vs_act = ({1'b0, r_v_cnt} >= VS_BEG) && ({1'b0, r_v_cnt} < VS_END);

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge counter values; blocking writes would skew colour against sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_rgb         <= '0;
            r_hsync       <= SYNC_IDLE;
            r_vsync       <= SYNC_IDLE;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + DIV_W'(1);
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
            if (w_tick) begin
                r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
                if (w_h_wrap) begin
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
                end
                r_rgb   <= w_active ? vga_rgb_in : 12'h000;
                r_hsync <= w_hs_act ? ~SYNC_IDLE : SYNC_IDLE;
                r_vsync <= w_vs_act ? ~SYNC_IDLE : SYNC_IDLE;
            end
        end
    end

    assign vga_pixel_x     = r_h_cnt;
    assign vga_pixel_y     = r_v_cnt;
    assign vga_r           = r_rgb[11:8];
    assign vga_g           = r_rgb[7:4];
    assign vga_b           = r_rgb[3:0];
    assign vga_hsync       = r_hsync;
    assign vga_vsync       = r_vsync;
    assign vga_frame_start = r_frame_start;

endmodule

// File: tb/tb_iob_vga_ctrl.sv
// Directed bench for iob_vga_ctrl on a shrunken 16x8 raster: a CLK_DIV=4 active-low
// instance and a CLK_DIV=1 active-high instance run side by side from one reset.
module tb_iob_vga_ctrl;

    // Raster: H 8+2+3+3 = 16, V 4+1+2+1 = 8; hsync at x 10..12, vsync at y 5..6.
    localparam int HT = 16;
    localparam int VT = 8;
    localparam int DA = 4;
    localparam int DB = 1;
    localparam int BIG = 1 << 30;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } obs_t;

    typedef struct {
        int run_start;
        bit in_run;
        int run_min;
        int run_max;
        int per_min;
        int per_max;
        int n_runs;
    } trk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mode = 1'b0;

    logic [9:0]  a_x, a_y, b_x, b_y;
    logic [11:0] a_rgb_in, b_rgb_in, a_rgb, b_rgb;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Image memory stand-in: flat white, or {x[3:0], y[3:0], 5}.
    assign a_rgb_in = mode ? {a_x[3:0], a_y[3:0], 4'h5} : 12'hFFF;
    assign b_rgb_in = mode ? {b_x[3:0], b_y[3:0], 4'h5} : 12'hFFF;
    assign a_rgb    = {a_r, a_g, a_b};
    assign b_rgb    = {b_r, b_g, b_b};

    iob_vga_ctrl #(
        .CLK_DIV(DA), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .vga_pixel_x(a_x), .vga_pixel_y(a_y), .vga_rgb_in(a_rgb_in),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_frame_start(a_fs)
    );

    iob_vga_ctrl #(
        .CLK_DIV(DB), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .vga_pixel_x(b_x), .vga_pixel_y(b_y), .vga_rgb_in(b_rgb_in),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_frame_start(b_fs)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected outputs t posedges after reset release: pixel p = t/d is on the
    // counters, and the registered outputs show pixel p-1.
    function automatic obs_t model(input int t, input int d, input bit pol, input bit md);
        obs_t m;
        int p, q, xq, yq;
        logic [9:0] xv, yv;
        p   = t / d;
        m.x = 10'(p % HT);
        m.y = 10'((p / HT) % VT);
        if (p == 0) begin
            m.rgb = '0;
            m.hs  = ~pol;
            m.vs  = ~pol;
        end else begin
            q  = p - 1;
            xq = q % HT;
            yq = (q / HT) % VT;
            xv = 10'(xq);
            yv = 10'(yq);
            if (xq < 8 && yq < 4) m.rgb = md ? {xv[3:0], yv[3:0], 4'h5} : 12'hFFF;
            else                  m.rgb = '0;
            m.hs = (xq >= 10 && xq < 13) ? pol : ~pol;
            m.vs = (yq >= 5 && yq < 7) ? pol : ~pol;
        end
        m.fs = (t % d == 0) && (p > 0) && (p % (HT * VT) == 0);
        return m;
    endfunction

    function automatic void trk_init(output trk_t k);
        k.run_start = -1;
        k.in_run    = 1'b0;
        k.run_min   = BIG;
        k.run_max   = 0;
        k.per_min   = BIG;
        k.per_max   = 0;
        k.n_runs    = 0;
    endfunction

    // Tracks length of asserted runs and spacing between their starts.
    function automatic void trk_step(inout trk_t k, input logic on, input int t);
        if (on && !k.in_run) begin
            if (k.run_start >= 0) begin
                if (t - k.run_start < k.per_min) k.per_min = t - k.run_start;
                if (t - k.run_start > k.per_max) k.per_max = t - k.run_start;
            end
            k.run_start = t;
            k.in_run    = 1'b1;
        end else if (!on && k.in_run) begin
            if (t - k.run_start < k.run_min) k.run_min = t - k.run_start;
            if (t - k.run_start > k.run_max) k.run_max = t - k.run_start;
            k.n_runs++;
            k.in_run = 1'b0;
        end
    endfunction

    task automatic sweep(input int n, input bit md,
                         output trk_t ta_hs, output trk_t ta_vs, output trk_t ta_fs,
                         output trk_t ta_rgb, output trk_t tb_hs, output trk_t tb_fs);
        obs_t ea, eb;
        int mm_a [6];
        int mm_b [6];
        for (int i = 0; i < 6; i++) begin
            mm_a[i] = 0;
            mm_b[i] = 0;
        end
        trk_init(ta_hs); trk_init(ta_vs); trk_init(ta_fs);
        trk_init(ta_rgb); trk_init(tb_hs); trk_init(tb_fs);
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            ea = model(t, DA, 1'b0, md);
            eb = model(t, DB, 1'b1, md);
            if (a_x   !== ea.x)   mm_a[0]++;
            if (a_y   !== ea.y)   mm_a[1]++;
            if (a_rgb !== ea.rgb) mm_a[2]++;
            if (a_hs  !== ea.hs)  mm_a[3]++;
            if (a_vs  !== ea.vs)  mm_a[4]++;
            if (a_fs  !== ea.fs)  mm_a[5]++;
            if (b_x   !== eb.x)   mm_b[0]++;
            if (b_y   !== eb.y)   mm_b[1]++;
            if (b_rgb !== eb.rgb) mm_b[2]++;
            if (b_hs  !== eb.hs)  mm_b[3]++;
            if (b_vs  !== eb.vs)  mm_b[4]++;
            if (b_fs  !== eb.fs)  mm_b[5]++;
            trk_step(ta_hs, a_hs == 1'b0, t);
            trk_step(ta_vs, a_vs == 1'b0, t);
            trk_step(ta_fs, a_fs, t);
            trk_step(ta_rgb, a_rgb != 12'h000, t);
            trk_step(tb_hs, b_hs == 1'b1, t);
            trk_step(tb_fs, b_fs, t);
            if (!md && t == 3)  check("a_x_before_first_tick", 32'(a_x), 0);
            if (!md && t == 4)  check("a_x_after_first_tick", 32'(a_x), 1);
            if (!md && t == 1)  check("b_x_after_first_tick", 32'(b_x), 1);
            if (md && t == 216) check("a_rgb_line3_px5", 32'(a_rgb), 32'h535);
            if (md && t == 219) check("a_rgb_line3_px5_hold", 32'(a_rgb), 32'h535);
            if (md && t == 232) check("a_rgb_line3_hblank", 32'(a_rgb), 0);
            if (md && t == 332) check("a_rgb_line5_vblank", 32'(a_rgb), 0);
            if (md && t == 54)  check("b_rgb_line3_px5", 32'(b_rgb), 32'h535);
        end
        check("a_x_trace",   32'(mm_a[0]), 0);
        check("a_y_trace",   32'(mm_a[1]), 0);
        check("a_rgb_trace", 32'(mm_a[2]), 0);
        check("a_hs_trace",  32'(mm_a[3]), 0);
        check("a_vs_trace",  32'(mm_a[4]), 0);
        check("a_fs_trace",  32'(mm_a[5]), 0);
        check("b_x_trace",   32'(mm_b[0]), 0);
        check("b_y_trace",   32'(mm_b[1]), 0);
        check("b_rgb_trace", 32'(mm_b[2]), 0);
        check("b_hs_trace",  32'(mm_b[3]), 0);
        check("b_vs_trace",  32'(mm_b[4]), 0);
        check("b_fs_trace",  32'(mm_b[5]), 0);
    endtask

    initial begin
        trk_t ta_hs, ta_vs, ta_fs, ta_rgb, tb_hs, tb_fs;
        int waited;

        // Reset values after 5 cycles of rst.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("rst_a_x",   32'(a_x), 0);
        check("rst_a_y",   32'(a_y), 0);
        check("rst_a_rgb", 32'(a_rgb), 0);
        check("rst_a_hs",  32'(a_hs), 1);
        check("rst_a_vs",  32'(a_vs), 1);
        check("rst_a_fs",  32'(a_fs), 0);
        check("rst_b_hs",  32'(b_hs), 0);
        check("rst_b_vs",  32'(b_vs), 0);

        // Two full frames of flat white on the divided instance.
        rst = 1'b0;
        sweep(1032, 1'b0, ta_hs, ta_vs, ta_fs, ta_rgb, tb_hs, tb_fs);
        check("a_hs_low_min",  32'(ta_hs.run_min), 12);
        check("a_hs_low_max",  32'(ta_hs.run_max), 12);
        check("a_hs_per_min",  32'(ta_hs.per_min), 64);
        check("a_hs_per_max",  32'(ta_hs.per_max), 64);
        check("a_rgb_on_min",  32'(ta_rgb.run_min), 32);
        check("a_rgb_on_max",  32'(ta_rgb.run_max), 32);
        check("a_vs_low_min",  32'(ta_vs.run_min), 128);
        check("a_vs_low_max",  32'(ta_vs.run_max), 128);
        check("a_vs_count",    32'(ta_vs.n_runs), 2);
        check("a_fs_width",    32'(ta_fs.run_max), 1);
        check("a_fs_count",    32'(ta_fs.n_runs), 2);
        check("a_fs_period",   32'(ta_fs.per_max), 512);
        check("b_hs_high_min", 32'(tb_hs.run_min), 3);
        check("b_hs_high_max", 32'(tb_hs.run_max), 3);
        check("b_hs_per",      32'(tb_hs.per_max), 16);
        check("b_fs_count",    32'(tb_fs.n_runs), 8);
        check("b_fs_per_min",  32'(tb_fs.per_min), 128);
        check("b_fs_per_max",  32'(tb_fs.per_max), 128);

        // Position-coded colour after a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mode = 1'b1;
        rst  = 1'b0;
        sweep(600, 1'b1, ta_hs, ta_vs, ta_fs, ta_rgb, tb_hs, tb_fs);

        // Reset in the middle of an hsync pulse.
        waited = 0;
        while (!(a_x == 10'd11 && a_y == 10'd2) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reach_x11_y2", 32'(a_x == 10'd11 && a_y == 10'd2), 1);
        check("mid_pre_hs", 32'(a_hs), 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_hs",  32'(a_hs), 1);
        check("mid_x",   32'(a_x), 0);
        check("mid_y",   32'(a_y), 0);
        check("mid_rgb", 32'(a_rgb), 0);
        rst = 1'b0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!a_fs && waited < 2000);
        check("mid_fs_delay", 32'(waited), 512);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
